// File: rtl/channel_demux_pkg.sv
// -----------------------------------------------------------------------------
// channel_demux_pkg
// Shared definitions for the channel demultiplexer slice.
//   CNT_W    : width of all statistics counters
//   EMPTY_W  : width of the empty-bytes field carried with every beat
//   state_e  : packet-routing FSM states
//   is_onehot: true when exactly one bit of the (zero-extended) vector is set
// -----------------------------------------------------------------------------
package channel_demux_pkg;

  localparam int CNT_W   = 32;
  localparam int EMPTY_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  // Channel vectors up to 32 bits are zero-extended into v by the caller.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/channel_demux_if.sv
// -----------------------------------------------------------------------------
// channel_demux_if
// Streaming bus for the demux: one upstream stream and NUM downstream streams.
//   in_*  : upstream beat (data/valid/sop/eop/empty/channel), in_ready and
//           in_almost_full flow back upstream
//   out_* : per-port beat, out_ready / out_almost_full flow back from each port
// Modports:
//   slave  : the demux view (consumes in_*, produces out_*)
//   master : the environment view (produces in_*, consumes out_*)
// -----------------------------------------------------------------------------
interface channel_demux_if
  import channel_demux_pkg::*;
#(
  parameter int WIDTH = 512,
  parameter int NUM   = 2
);

  logic [WIDTH-1:0]                in_data;
  logic                            in_valid;
  logic                            in_ready;
  logic                            in_sop;
  logic                            in_eop;
  logic [EMPTY_W-1:0]              in_empty;
  logic [NUM-1:0]                  in_channel;
  logic                            in_almost_full;

  logic [NUM-1:0][WIDTH-1:0]       out_data;
  logic [NUM-1:0]                  out_valid;
  logic [NUM-1:0]                  out_sop;
  logic [NUM-1:0]                  out_eop;
  logic [NUM-1:0][EMPTY_W-1:0]     out_empty;
  logic [NUM-1:0][NUM-1:0]         out_channel;
  logic [NUM-1:0]                  out_ready;
  logic [NUM-1:0]                  out_almost_full;

  modport slave (
    input  in_data, in_valid, in_sop, in_eop, in_empty, in_channel,
    output in_ready, in_almost_full,
    output out_data, out_valid, out_sop, out_eop, out_empty, out_channel,
    input  out_ready, out_almost_full
  );

  modport master (
    output in_data, in_valid, in_sop, in_eop, in_empty, in_channel,
    input  in_ready, in_almost_full,
    input  out_data, out_valid, out_sop, out_eop, out_empty, out_channel,
    output out_ready, out_almost_full
  );

endinterface

// File: rtl/channel_demux_chan_skid_buf.sv
// -----------------------------------------------------------------------------
// chan_skid_buf
// Two-entry skid buffer for one output port. The head entry drives the port.
//   clk, rst   : clock, synchronous active-high reset (empties the buffer)
//   push       : write push_data this cycle (caller guarantees !full)
//   push_data  : payload {data, sop, eop, empty}
//   full       : both entries occupied (registered state only)
//   pop_ready  : downstream ready; head leaves when head_valid && pop_ready
//   head_valid : buffer not empty
//   head_data  : oldest payload
// -----------------------------------------------------------------------------
module chan_skid_buf #(
  parameter int PW = 520
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [PW-1:0] push_data,
  output logic          full,
  input  logic          pop_ready,
  output logic          head_valid,
  output logic [PW-1:0] head_data
);

  logic [1:0]    occ_r;
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic          pop_s;

  assign pop_s      = head_valid && pop_ready;
  assign head_valid = (occ_r != 2'd0);
  assign full       = (occ_r == 2'd2);
  assign head_data  = head_r;

  // Occupancy tracking; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_r <= 2'd0;
    end else begin
      case ({push, pop_s})
        2'b10:   occ_r <= occ_r + 2'd1;
        2'b01:   occ_r <= occ_r - 2'd1;
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Payload storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    case ({push, pop_s})
      2'b10: begin
        if (occ_r == 2'd0) begin
          head_r <= push_data;
        end else begin
          tail_r <= push_data;
        end
      end
      2'b01: begin
        // At occupancy 1 the copy is harmless: the head becomes invalid.
        head_r <= tail_r;
      end
      2'b11: begin
        if (occ_r == 2'd1) begin
          head_r <= push_data;
        end else begin
          head_r <= tail_r;
          tail_r <= push_data;
        end
      end
      default: begin
        head_r <= head_r;
      end
    endcase
  end

endmodule

// File: rtl/channel_demux.sv
// -----------------------------------------------------------------------------
// channel_demux
// Routes packets from one input stream to one of NUM output streams selected
// by the one-hot channel carried on the sop beat. Malformed framing is
// repaired or dropped and counted.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : channel_demux_if.slave (input stream, NUM output streams)
//   pkt_cnt   : per-port count of eop beats forwarded (wraps)
//   drop_cnt  : packets discarded for a zero / multi-hot channel (wraps)
//   err_cnt   : framing errors: stray non-sop in idle, sop inside packet
// -----------------------------------------------------------------------------
module channel_demux
  import channel_demux_pkg::*;
#(
  parameter int WIDTH = 512,
  parameter int NUM   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  channel_demux_if.slave            bus,
  output logic [NUM-1:0][CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0]          drop_cnt,
  output logic [CNT_W-1:0]          err_cnt
);

  localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int PW    = WIDTH + 2 + EMPTY_W;

  state_e                    state_r;
  state_e                    state_nxt_s;
  logic [IDX_W-1:0]          port_r;
  logic [IDX_W-1:0]          port_nxt_s;
  logic [IDX_W-1:0]          ch_idx_s;
  logic                      ch_ok_s;
  logic [NUM-1:0]            full_s;
  logic                      in_ready_s;
  logic                      accept_s;
  logic [NUM-1:0]            push_s;
  logic                      push_sop_s;
  logic                      push_eop_s;
  logic                      drop_inc_s;
  logic                      err_inc_s;
  logic [PW-1:0]             push_data_s;
  logic                      in_almost_full_r;
  logic [NUM-1:0][CNT_W-1:0] pkt_cnt_r;
  logic [CNT_W-1:0]          drop_cnt_r;
  logic [CNT_W-1:0]          err_cnt_r;

  assign ch_ok_s     = is_onehot(32'(bus.in_channel));
  assign accept_s    = bus.in_valid && in_ready_s;
  assign push_data_s = {bus.in_data, push_sop_s, push_eop_s, bus.in_empty};

  // Index of the set channel bit; only meaningful when ch_ok_s.
  always_comb begin
    ch_idx_s = {IDX_W{1'b0}};
    for (int k = 0; k < NUM; k++) begin
      ch_idx_s = bus.in_channel[k] ? IDX_W'(k) : ch_idx_s;
    end
  end

  // Ready depends only on registered buffer fullness, never on out_ready.
  always_comb begin
    in_ready_s = 1'b1;
    case (state_r)
      ST_IDLE: in_ready_s = ch_ok_s ? !full_s[ch_idx_s] : 1'b1;
      ST_FWD:  in_ready_s = !full_s[port_r];
      ST_DROP: in_ready_s = 1'b1;
      default: in_ready_s = 1'b1;
    endcase
  end

  // FSM next state, per-port push strobes and framing repair.
  always_comb begin
    state_nxt_s = state_r;
    port_nxt_s  = port_r;
    push_s      = {NUM{1'b0}};
    push_sop_s  = bus.in_sop;
    push_eop_s  = bus.in_eop;
    drop_inc_s  = 1'b0;
    err_inc_s   = 1'b0;
    if (accept_s) begin
      case (state_r)
        ST_IDLE: begin
          if (!bus.in_sop) begin
            err_inc_s = 1'b1;
          end else if (ch_ok_s) begin
            port_nxt_s         = ch_idx_s;
            push_s[ch_idx_s]   = 1'b1;
            state_nxt_s        = bus.in_eop ? ST_IDLE : ST_FWD;
          end else begin
            drop_inc_s  = 1'b1;
            state_nxt_s = bus.in_eop ? ST_IDLE : ST_DROP;
          end
        end
        ST_FWD: begin
          push_s[port_r] = 1'b1;
          if (bus.in_sop) begin
            // A new sop closes the open packet; the new packet is discarded.
            push_sop_s  = 1'b0;
            push_eop_s  = 1'b1;
            err_inc_s   = 1'b1;
            state_nxt_s = bus.in_eop ? ST_IDLE : ST_DROP;
          end else begin
            state_nxt_s = bus.in_eop ? ST_IDLE : ST_FWD;
          end
        end
        ST_DROP: begin
          state_nxt_s = bus.in_eop ? ST_IDLE : ST_DROP;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM state and latched destination port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      port_r  <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      port_r  <= port_nxt_s;
    end
  end

  // Statistics counters; wrap naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_r  <= '0;
      drop_cnt_r <= {CNT_W{1'b0}};
      err_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      for (int k = 0; k < NUM; k++) begin
        if (push_s[k] && push_eop_s) begin
          pkt_cnt_r[k] <= pkt_cnt_r[k] + 32'd1;
        end
      end
      if (drop_inc_s) begin
        drop_cnt_r <= drop_cnt_r + 32'd1;
      end
      if (err_inc_s) begin
        err_cnt_r <= err_cnt_r + 32'd1;
      end
    end
  end

  // Upstream backpressure hint: any downstream hint or any full buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_almost_full_r <= 1'b0;
    end else begin
      in_almost_full_r <= (|bus.out_almost_full) | (|full_s);
    end
  end

  for (genvar k = 0; k < NUM; k++) begin : g_port
    logic [PW-1:0] head_s;
    logic          head_valid_s;

    chan_skid_buf #(.PW(PW)) u_skid (
      .clk        (clk),
      .rst        (rst),
      .push       (push_s[k]),
      .push_data  (push_data_s),
      .full       (full_s[k]),
      .pop_ready  (bus.out_ready[k]),
      .head_valid (head_valid_s),
      .head_data  (head_s)
    );

    assign bus.out_valid[k]   = head_valid_s;
    assign bus.out_data[k]    = head_s[PW-1 -: WIDTH];
    assign bus.out_sop[k]     = head_s[EMPTY_W+1];
    assign bus.out_eop[k]     = head_s[EMPTY_W];
    assign bus.out_empty[k]   = head_s[EMPTY_W-1:0];
    assign bus.out_channel[k] = NUM'(1'b1) << k;
  end

  assign bus.in_ready       = in_ready_s;
  assign bus.in_almost_full = in_almost_full_r;
  assign pkt_cnt            = pkt_cnt_r;
  assign drop_cnt           = drop_cnt_r;
  assign err_cnt            = err_cnt_r;

endmodule

// File: doc/channel_demux.md
CHANNEL_DEMUX -- requirements
Module: channel_demux

Interface
REQ-001 Parameter WIDTH, default 512: data bus width in bits.
REQ-002 Parameter NUM, default 2: number of output ports; channel field is NUM bits, one-hot destination.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_data  input  WIDTH  beat data.
REQ-006 in_valid  input  1  beat valid.
REQ-007 in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-008 in_sop / in_eop  input  1 each  packet first / last beat.
REQ-009 in_empty  input  6  unused bytes in eop beat.
REQ-010 in_channel  input  NUM  one-hot destination, sampled on sop beat only.
REQ-011 in_almost_full  output  1  registered backpressure hint to upstream.
REQ-012 out_data/out_valid/out_sop/out_eop/out_empty  output  NUM x (WIDTH/1/1/1/6)  per-port stream.
REQ-013 out_ready  input  NUM  per-port ready.
REQ-014 out_almost_full  input  NUM  per-port downstream hint.
REQ-015 out_channel  output  NUM x NUM  equals the port's one-hot bit (constant).
REQ-016 pkt_cnt  output  NUM x 32  packets forwarded per port; drop_cnt  output  32; err_cnt  output  32.

Function
REQ-017 Each port SHALL own a 2-entry skid buffer; out_* SHALL be driven from its head, out_valid = occupancy != 0.
REQ-018 Latency SHALL be exactly 1 cycle: beat accepted at cycle N is visible on its port at N+1 if buffer empty.
REQ-019 Buffer SHALL pop on out_valid && out_ready; push+pop at occupancy 1 SHALL keep occupancy 1; full throughput 1 beat/cycle sustained.
REQ-020 in_ready SHALL never depend combinationally on out_ready: in_ready = 1 in DROP, else !full[dest]; dest = decoded in_channel in IDLE (1 if channel not one-hot), latched port in FWD.
REQ-021 FSM states IDLE, FWD, DROP; reset state IDLE.
REQ-022 IDLE, accepted sop, one-hot channel: latch port, forward beat; next FWD, or IDLE if eop.
REQ-023 IDLE, accepted sop, channel zero or multi-hot: discard, drop_cnt+1; next DROP, or IDLE if eop.
REQ-024 IDLE, accepted non-sop beat: discard, err_cnt+1, stay IDLE.
REQ-025 FWD, accepted non-sop beat: forward to latched port unchanged; eop -> IDLE.
REQ-026 FWD, accepted sop beat: forward to latched port with sop forced 0, eop forced 1 (terminates old packet), err_cnt+1; next DROP, or IDLE if beat eop.
REQ-027 DROP: accept and discard every beat; eop -> IDLE.
REQ-028 pkt_cnt[k] SHALL increment when an eop beat is pushed to port k; all counters wrap modulo 2^32.
REQ-029 data and empty SHALL pass through unmodified; no beat reorders within a port.
REQ-030 in_almost_full SHALL be registered OR of all out_almost_full and all buffers full.

Reset
REQ-031 On rst: state IDLE, occupancies 0, out_valid 0, counters 0, in_almost_full 0; out_data/out_empty don't-care.
REQ-032 rst mid-packet SHALL discard buffered beats; truncation downstream is accepted; first post-reset beat evaluated in IDLE.

Structure
REQ-033 Shared package SHALL hold the FSM state enum, CNT_W=32, EMPTY_W=6.
REQ-034 Sub-module chan_skid_buf (2-entry skid, WIDTH+8 bits payload) SHALL be instantiated NUM times.

Verification
REQ-035 NUM=2, 3-beat pkt channel=2'b10, out_ready=1 -> beats on port1 at cycles N+1..N+3, pkt_cnt[1]=1, port0 idle.
REQ-036 Back-to-back 1-beat pkts alternating 01/10, all ready -> in_ready constant 1, 1 beat/cycle, pkt_cnt={5,5} after 10.
REQ-037 out_ready[0]=0 with 4-beat pkt to port0 -> in_ready falls after 2 beats accepted, no loss, resume on out_ready=1.
REQ-038 sop with channel=2'b11, 3 beats -> nothing forwarded, drop_cnt=1, err_cnt=0, next valid pkt forwarded.
REQ-039 sop mid-FWD -> old packet ends with eop=1 on that beat, remainder dropped, err_cnt=1; stray non-sop in IDLE -> err_cnt=2.
REQ-040 rst asserted mid-packet -> next cycle all out_valid=0, counters 0, state IDLE.
